// File: rtl/instruction_encoder_loader.sv
// Encodes symbolic RV32IM requests into instruction words and
// streams them into instruction memory through a backpressured port.
module instruction_encoder_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [5:0]            opSel,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  memValid,
    input  logic                  memReady,
    output logic [ADDR_WIDTH-1:0] memWrAddr,
    output logic [31:0]           memWrData,
    output logic [ADDR_WIDTH:0]   wordCount,
    output logic                  full,
    output logic                  error
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_W  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_X
    } fmt_t;

    fmt_t        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] enc;
    logic        legal;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        room;
    logic        accept;
    logic        mem_fire;
    logic [ADDR_WIDTH+1:0] issued;

    // Immediate fits the signed field width of each format
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    // Words written plus the one in flight must stay within DEPTH,
    // otherwise a word accepted on the last slot would overrun full
    assign issued = (ADDR_WIDTH + 2)'(wordCount)
                  + (ADDR_WIDTH + 2)'(memValid);
    assign room   = issued < (ADDR_WIDTH + 2)'(DEPTH_W);
    assign full   = (wordCount == DEPTH_W);

    assign inReady  = room && (!memValid || memReady) && !reset && !clear;
    assign accept   = inValid && inReady;
    assign mem_fire = memValid && memReady;

    // Map the operation selector to format, opcode and function fields
    always_comb begin
        fmt    = FMT_X;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        case (opSel)
            6'd0:  begin fmt = FMT_R; opcode = OPC_OP; end
            6'd1:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'h20; end
            6'd2:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'h01; end
            6'd3:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'h01; funct3 = 3'd4; end
            6'd4:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'h01; funct3 = 3'd5; end
            6'd5:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'h01; funct3 = 3'd6; end
            6'd6:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'h01; funct3 = 3'd7; end
            6'd7:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = 3'd2; end
            6'd8:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = 3'd3; end
            6'd9:  begin fmt = FMT_I; opcode = OPC_OP_IMM; end
            6'd10: begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = 3'd2; end
            6'd11: begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = 3'd3; end
            6'd12: begin fmt = FMT_J; opcode = OPC_JAL; end
            6'd13: begin fmt = FMT_I; opcode = OPC_JALR; end
            6'd14: begin fmt = FMT_B; opcode = OPC_BRANCH; end
            6'd15: begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'd1; end
            6'd16: begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'd4; end
            6'd17: begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'd5; end
            6'd18: begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'd6; end
            6'd19: begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'd7; end
            6'd20: begin fmt = FMT_I; opcode = OPC_LOAD; end
            6'd21: begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'd1; end
            6'd22: begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'd2; end
            6'd23: begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'd4; end
            6'd24: begin fmt = FMT_I; opcode = OPC_LOAD; funct3 = 3'd5; end
            6'd25: begin fmt = FMT_S; opcode = OPC_STORE; end
            6'd26: begin fmt = FMT_S; opcode = OPC_STORE; funct3 = 3'd1; end
            6'd27: begin fmt = FMT_S; opcode = OPC_STORE; funct3 = 3'd2; end
            6'd28: begin fmt = FMT_U; opcode = OPC_LUI; end
            6'd29: begin fmt = FMT_U; opcode = OPC_AUIPC; end
            default: fmt = FMT_X;
        endcase
    end

    // Assemble the instruction word and judge immediate legality
    always_comb begin
        enc   = '0;
        legal = 1'b0;
        unique case (fmt)
            FMT_R: begin
                enc   = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                enc   = {imm[11:0], rs1, funct3, rd, opcode};
                legal = fits12;
            end
            FMT_S: begin
                enc   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = fits12;
            end
            FMT_B: begin
                enc   = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
                legal = fits13 && !imm[0];
            end
            FMT_J: begin
                enc   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = fits21 && !imm[0];
            end
            FMT_U: begin
                enc   = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_X: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    // Output word register, write address, word counter and sticky error
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            memValid  <= 1'b0;
            memWrAddr <= BASE_W;
            memWrData <= '0;
            wordCount <= '0;
            error     <= 1'b0;
        end else begin
            if (mem_fire) begin
                memWrAddr <= memWrAddr + ONE_A;
                wordCount <= wordCount + ONE_C;
            end
            if (accept && legal) begin
                memValid  <= 1'b1;
                memWrData <= enc;
            end else if (mem_fire) begin
                memValid <= 1'b0;
            end
            if (accept && !legal) begin
                error <= 1'b1;
            end
        end
    end

endmodule
